// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// A fetch buffer entry pairs each returned instruction with the address it was read from.
package fetch_unit_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_data;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Fetch buffer: small synchronous FIFO of {pc, instr} entries.
// Flush empties it and wins over a same-cycle push.
module fetch_unit_fifo
    import fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  fetch_data        i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output fetch_data        o_head,
    output logic [CNT_W-1:0] o_count
);

    fetch_data        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push && !i_flush;
    assign w_do_pop  = i_pop && !i_flush && (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues sequential reads to a
// one-cycle-latency instruction memory and hands {instr, pc} to decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    input  logic        ready_in
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0] r_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;

    logic [CNT_W-1:0] w_count;
    logic [CNT_W:0]   w_occupancy;
    fetch_data        w_head;
    fetch_data        w_push_data;
    logic             w_valid;
    logic             w_pop;
    logic             w_push;
    logic             w_issue;

    assign w_valid = (w_count != '0);
    assign w_pop   = w_valid && ready_in;
    assign w_push  = r_inflight && !redirect_valid;

    // Slots already claimed once this cycle's pop retires; a new read is only
    // launched if its data is guaranteed a slot when it returns.
    assign w_occupancy = {1'b0, w_count} + (CNT_W + 1)'(r_inflight) - (CNT_W + 1)'(w_pop);
    assign w_issue     = !redirect_valid && (w_occupancy < (CNT_W + 1)'(DEPTH));

    assign w_push_data.pc    = r_inflight_pc;
    assign w_push_data.instr = imem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_valid) begin
            r_pc       <= align_word(redirect_pc);
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_pc          <= r_pc + 32'(INSTR_BYTES);
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    fetch_unit_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_data(w_push_data),
        .i_pop      (w_pop),
        .i_flush    (redirect_valid),
        .o_head     (w_head),
        .o_count    (w_count)
    );

    // Request is masked during reset so memory sees no reads while rst_n is low.
    assign imem_en   = w_issue && rst_n;
    assign imem_addr = r_pc;

    assign valid_out = w_valid;
    assign instr_out = w_valid ? w_head.instr : '0;
    assign pc_out    = w_valid ? w_head.pc    : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: startup, backpressure, redirects, PC wrap,
// a random-ready stream with scoreboard, and reset mid-stream.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] XORV   = 32'hA5A5_0000;
    localparam int          DEPTH  = 2;

    logic        clk;
    logic        rst_n;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        ready_in;

    int errors = 0;
    int checks = 0;
    logic seen_400 = 1'b0;

    fetch_unit #(
        .RESET_PC(RST_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: data is a fixed function of the address.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_addr ^ XORV;
        if (rst_n && imem_en && imem_addr == 32'h0000_0400) seen_400 <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Enter the next cycle: drive inputs at the falling edge, settle, then sample.
    task automatic go(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        ready_in       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic assert_reset(input logic rdy);
        @(negedge clk);
        rst_n          = 1'b0;
        ready_in       = rdy;
        redirect_valid = 1'b0;
        #1;
    endtask

    task automatic release_reset(input logic rdy);
        @(negedge clk);
        rst_n          = 1'b1;
        ready_in       = rdy;
        redirect_valid = 1'b0;
        #1;
    endtask

    initial begin : stim
        int          issued;
        int          popped;
        logic [31:0] exp_pc;
        logic        hold_prev;
        logic [31:0] hold_pc;

        rst_n          = 1'b0;
        ready_in       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rdata     = '0;
        #1;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_imem_en", 32'(imem_en), 32'd0);
        @(negedge clk);

        // ---- startup stream, ready_in = 1
        release_reset(1'b1);
        chk("s0_en", 32'(imem_en), 32'd1);
        chk("s0_addr", imem_addr, 32'h100);
        chk("s0_valid", 32'(valid_out), 32'd0);
        go(1'b1, 1'b0, '0);
        chk("s1_addr", imem_addr, 32'h104);
        chk("s1_valid", 32'(valid_out), 32'd0);
        for (int k = 0; k < 5; k++) begin
            go(1'b1, 1'b0, '0);
            chk("s_valid", 32'(valid_out), 32'd1);
            chk("s_pc", pc_out, 32'h100 + 32'(4 * k));
            chk("s_instr", instr_out, (32'h100 + 32'(4 * k)) ^ XORV);
            chk("s_addr", imem_addr, 32'h108 + 32'(4 * k));
        end

        // ---- backpressure from cycle 0
        assert_reset(1'b0);
        chk("mid_rst_valid", 32'(valid_out), 32'd0);
        release_reset(1'b0);
        chk("b0_addr", imem_addr, 32'h100);
        go(1'b0, 1'b0, '0);
        chk("b1_en", 32'(imem_en), 32'd1);
        chk("b1_addr", imem_addr, 32'h104);
        for (int k = 2; k < 5; k++) begin
            go(1'b0, 1'b0, '0);
            chk("b_en_off", 32'(imem_en), 32'd0);
            chk("b_hold_valid", 32'(valid_out), 32'd1);
            chk("b_hold_pc", pc_out, 32'h100);
            chk("b_hold_instr", instr_out, 32'hA5A5_0100);
        end
        go(1'b1, 1'b0, '0);
        chk("b5_pc", pc_out, 32'h100);
        chk("b5_addr", imem_addr, 32'h108);
        chk("b5_en", 32'(imem_en), 32'd1);
        go(1'b1, 1'b0, '0);
        chk("b6_pc", pc_out, 32'h104);
        chk("b6_addr", imem_addr, 32'h10C);
        go(1'b1, 1'b0, '0);
        chk("b7_valid", 32'(valid_out), 32'd1);
        chk("b7_pc", pc_out, 32'h108);

        // ---- redirect while buffer occupied and a read in flight
        assert_reset(1'b0);
        release_reset(1'b0);
        go(1'b0, 1'b0, '0);
        go(1'b0, 1'b1, 32'h0000_2002);
        chk("r_cycle_en", 32'(imem_en), 32'd0);
        chk("r_cycle_head", pc_out, 32'h100);
        go(1'b0, 1'b0, '0);
        chk("r1_en", 32'(imem_en), 32'd1);
        chk("r1_addr", imem_addr, 32'h2000);
        chk("r1_valid", 32'(valid_out), 32'd0);
        go(1'b0, 1'b0, '0);
        chk("r2_valid", 32'(valid_out), 32'd0);
        chk("r2_addr", imem_addr, 32'h2004);
        go(1'b1, 1'b0, '0);
        chk("r3_valid", 32'(valid_out), 32'd1);
        chk("r3_pc", pc_out, 32'h2000);
        chk("r3_instr", instr_out, 32'hA5A5_2000);
        go(1'b1, 1'b0, '0);
        chk("r4_pc", pc_out, 32'h2004);
        go(1'b1, 1'b0, '0);
        chk("r5_pc", pc_out, 32'h2008);

        // ---- back-to-back redirects: last one wins
        go(1'b1, 1'b1, 32'h0000_0400);
        chk("bb0_en", 32'(imem_en), 32'd0);
        go(1'b1, 1'b1, 32'h0000_0800);
        chk("bb1_en", 32'(imem_en), 32'd0);
        chk("bb1_valid", 32'(valid_out), 32'd0);
        go(1'b1, 1'b0, '0);
        chk("bb2_addr", imem_addr, 32'h800);
        chk("bb2_valid", 32'(valid_out), 32'd0);
        go(1'b1, 1'b0, '0);
        chk("bb3_addr", imem_addr, 32'h804);
        chk("bb3_valid", 32'(valid_out), 32'd0);
        go(1'b1, 1'b0, '0);
        chk("bb4_pc", pc_out, 32'h800);
        go(1'b1, 1'b0, '0);
        chk("bb5_pc", pc_out, 32'h804);
        chk("never_issued_400", 32'(seen_400), 32'd0);

        // ---- PC wrap; low redirect bits ignored
        go(1'b1, 1'b1, 32'hFFFF_FFFF);
        go(1'b1, 1'b0, '0);
        chk("w0_addr", imem_addr, 32'hFFFF_FFFC);
        go(1'b1, 1'b0, '0);
        chk("w1_addr", imem_addr, 32'h0000_0000);
        go(1'b1, 1'b0, '0);
        chk("w2_pc", pc_out, 32'hFFFF_FFFC);
        chk("w2_instr", instr_out, 32'h5A5A_FFFC);
        go(1'b1, 1'b0, '0);
        chk("w3_pc", pc_out, 32'h0000_0000);
        chk("w3_instr", instr_out, 32'hA5A5_0000);

        // ---- random ready_in with scoreboard
        assert_reset(1'b0);
        issued    = 0;
        popped    = 0;
        exp_pc    = RST_PC;
        hold_prev = 1'b0;
        hold_pc   = '0;
        release_reset(1'b0);
        for (int n = 0; n < 1000; n++) begin
            if (n != 0) go(1'($urandom_range(0, 2) != 0), 1'b0, '0);
            if (imem_en) issued++;
            if (hold_prev) begin
                chk("rand_hold_valid", 32'(valid_out), 32'd1);
                chk("rand_hold_pc", pc_out, hold_pc);
            end
            if (valid_out && ready_in) begin
                chk("rand_pc", pc_out, exp_pc);
                chk("rand_instr", instr_out, exp_pc ^ XORV);
                exp_pc = exp_pc + 32'd4;
                popped++;
            end
            hold_prev = valid_out && !ready_in;
            hold_pc   = pc_out;
            checks++;
            assert (issued - popped <= DEPTH)
            else begin
                errors++;
                $error("FAIL rand_occupancy: observed=%0d expected<=%0d", issued - popped, DEPTH);
            end
        end
        checks++;
        assert (popped > 300)
        else begin
            errors++;
            $error("FAIL rand_throughput: observed=%0d expected>300", popped);
        end

        // ---- reset mid-stream with entries buffered
        go(1'b0, 1'b0, '0);
        go(1'b0, 1'b0, '0);
        go(1'b0, 1'b0, '0);
        chk("pre_rst_valid", 32'(valid_out), 32'd1);
        assert_reset(1'b0);
        chk("mrst_valid", 32'(valid_out), 32'd0);
        chk("mrst_pc", pc_out, 32'd0);
        chk("mrst_instr", instr_out, 32'd0);
        chk("mrst_en", 32'(imem_en), 32'd0);
        release_reset(1'b1);
        chk("mr0_addr", imem_addr, RST_PC);
        chk("mr0_valid", 32'(valid_out), 32'd0);
        go(1'b1, 1'b0, '0);
        chk("mr1_valid", 32'(valid_out), 32'd0);
        chk("mr1_addr", imem_addr, 32'h104);
        go(1'b1, 1'b0, '0);
        chk("mr2_valid", 32'(valid_out), 32'd1);
        chk("mr2_pc", pc_out, RST_PC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
